// File: rtl/time_set_pkg.sv
// Shared definitions for the time-set controller: FSM states, button
// indices, production timing defaults and the button priority helper.
package time_set_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_FIRE     = 3'd2,
    ST_HOLD     = 3'd3,
    ST_REPEAT   = 3'd4,
    ST_WAIT_REL = 3'd5
  } state_t;

  localparam int BTN_HR_UP  = 3;
  localparam int BTN_HR_DN  = 2;
  localparam int BTN_MIN_UP = 1;
  localparam int BTN_MIN_DN = 0;

  // Defaults assume a 100 MHz clock.
  localparam int DEF_DEB_CYCLES = 1_000_000;   // 10 ms
  localparam int DEF_RPT_DELAY  = 50_000_000;  // 500 ms
  localparam int DEF_RPT_PERIOD = 10_000_000;  // 100 ms
  localparam int DEF_BLINK_HALF = 25_000_000;  // 250 ms

  // Index of the highest-numbered pressed button (hour up wins over all).
  function automatic logic [1:0] prio_sel(input logic [3:0] lv);
    logic [1:0] s;
    s = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (lv[i]) s = 2'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit button conditioner: two-flop synchronizer followed by a
// stable-level debouncer. The output only follows the input once it has
// been seen low for DEB_CYCLES cycles after reset, so a button held
// through reset cannot produce a press until it is released first.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] C_TERM = CW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_qual;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
    end
  end

  // Count consecutive cycles at a new level; qualify on a first stable low.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_qual  <= 1'b0;
    end else if (!r_qual) begin
      if (r_s2) begin
        r_cnt <= '0;
      end else if (r_cnt == C_TERM) begin
        r_qual <= 1'b1;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end else if (r_s2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == C_TERM) begin
      r_level <= r_s2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set controller: turns four debounced buttons into single-cycle
// hour/minute increment/decrement commands with auto-repeat, freezes the
// time counter while set mode is enabled and drives a display blink phase.
module time_set_ctrl
  import time_set_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int RPT_DELAY  = DEF_RPT_DELAY,
  parameter int RPT_PERIOD = DEF_RPT_PERIOD,
  parameter int BLINK_HALF = DEF_BLINK_HALF
) (
  input  logic       CLK_100MHZ,
  input  logic       RST,
  input  logic [3:0] BTN,
  input  logic       SET_EN,
  output logic       HR_INC,
  output logic       HR_DEC,
  output logic       MIN_INC,
  output logic       MIN_DEC,
  output logic       SEC_CLR,
  output logic       TICK_HOLD,
  output logic       BLINK
);

  localparam int HW = (RPT_DELAY  > 1) ? $clog2(RPT_DELAY)  : 1;
  localparam int PW = (RPT_PERIOD > 1) ? $clog2(RPT_PERIOD) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [HW-1:0] HOLD_TERM  = HW'(RPT_DELAY - 1);
  localparam logic [PW-1:0] RPT_TERM   = PW'(RPT_PERIOD - 1);
  localparam logic [BW-1:0] BLINK_TERM = BW'(BLINK_HALF - 1);

  logic [3:0]    w_deb;
  logic          w_any;
  logic          w_sel_held;
  logic          w_fire;
  state_t        r_state;
  state_t        w_state_nx;
  logic [1:0]    r_sel;
  logic [1:0]    w_sel_nx;
  logic [HW-1:0] r_hold_cnt;
  logic [PW-1:0] r_rpt_cnt;
  logic [BW-1:0] r_blink_cnt;
  logic          r_blink;
  logic [3:0]    r_cmd;
  logic          r_sec_clr;

  for (genvar g = 0; g < 4; g++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .i_clk   (CLK_100MHZ),
      .i_rst   (RST),
      .i_btn   (BTN[g]),
      .o_level (w_deb[g])
    );
  end

  assign w_any      = |w_deb;
  assign w_sel_held = w_deb[r_sel];

  // Next state, latched button and command request; dropping SET_EN wins.
  always_comb begin
    w_state_nx = r_state;
    w_sel_nx   = r_sel;
    w_fire     = 1'b0;
    if (r_state != ST_IDLE && !SET_EN) begin
      w_state_nx = ST_IDLE;
      w_sel_nx   = 2'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (SET_EN) w_state_nx = ST_ARMED;
        end
        ST_ARMED: begin
          if (w_any) begin
            w_sel_nx   = prio_sel(w_deb);
            w_state_nx = ST_FIRE;
          end
        end
        ST_FIRE: begin
          w_fire     = 1'b1;
          w_state_nx = ST_HOLD;
        end
        ST_HOLD: begin
          if (!w_sel_held) begin
            w_state_nx = w_any ? ST_WAIT_REL : ST_ARMED;
          end else if (r_hold_cnt == HOLD_TERM) begin
            // First repeat pulse lands exactly RPT_DELAY after the press pulse.
            w_fire     = 1'b1;
            w_state_nx = ST_REPEAT;
          end
        end
        ST_REPEAT: begin
          if (!w_sel_held) begin
            w_state_nx = w_any ? ST_WAIT_REL : ST_ARMED;
          end else if (r_rpt_cnt == RPT_TERM) begin
            w_fire = 1'b1;
          end
        end
        ST_WAIT_REL: begin
          if (!w_any) w_state_nx = ST_ARMED;
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  // State and latched-button registers.
  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_sel   <= 2'd0;
    end else begin
      r_state <= w_state_nx;
      r_sel   <= w_sel_nx;
    end
  end

  // Hold counter runs only while staying in HOLD and stops at its terminal value.
  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      r_hold_cnt <= '0;
    end else if (r_state == ST_HOLD && w_state_nx == ST_HOLD) begin
      if (r_hold_cnt != HOLD_TERM) r_hold_cnt <= r_hold_cnt + 1'b1;
    end else begin
      r_hold_cnt <= '0;
    end
  end

  // Repeat period counter restarts after each repeat pulse.
  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      r_rpt_cnt <= '0;
    end else if (r_state == ST_REPEAT && w_state_nx == ST_REPEAT) begin
      r_rpt_cnt <= (r_rpt_cnt == RPT_TERM) ? '0 : r_rpt_cnt + 1'b1;
    end else begin
      r_rpt_cnt <= '0;
    end
  end

  // Blink phase runs throughout set mode and restarts at phase 0 from IDLE.
  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_state == ST_IDLE || w_state_nx == ST_IDLE) begin
      r_blink_cnt <= '0;
      r_blink     <= 1'b0;
    end else if (r_blink_cnt == BLINK_TERM) begin
      r_blink_cnt <= '0;
      r_blink     <= ~r_blink;
    end else begin
      r_blink_cnt <= r_blink_cnt + 1'b1;
    end
  end

  // Registered one-hot command pulse; minute commands also clear seconds.
  always_ff @(posedge CLK_100MHZ or posedge RST) begin
    if (RST) begin
      r_cmd     <= 4'd0;
      r_sec_clr <= 1'b0;
    end else begin
      r_cmd     <= w_fire ? (4'b0001 << r_sel) : 4'd0;
      r_sec_clr <= w_fire && (r_sel == 2'(BTN_MIN_UP) || r_sel == 2'(BTN_MIN_DN));
    end
  end

  assign HR_INC    = r_cmd[BTN_HR_UP];
  assign HR_DEC    = r_cmd[BTN_HR_DN];
  assign MIN_INC   = r_cmd[BTN_MIN_UP];
  assign MIN_DEC   = r_cmd[BTN_MIN_DN];
  assign SEC_CLR   = r_sec_clr;
  assign TICK_HOLD = (r_state != ST_IDLE);
  assign BLINK     = r_blink && (r_state == ST_ARMED || r_state == ST_WAIT_REL);

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl with scaled timing: a behavioural model derived
// from press-duration arithmetic, a per-cycle compare process and directed
// scenarios with hand-computed pulse counts and timings.
module tb_time_set_ctrl;

  localparam int DEB = 4;
  localparam int RD  = 20;
  localparam int RP  = 5;
  localparam int BH  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       set_en = 1'b0;
  logic [3:0] btn = 4'd0;
  logic       hr_inc, hr_dec, min_inc, min_dec, sec_clr, tick_hold, blink;

  time_set_ctrl #(
    .DEB_CYCLES(DEB), .RPT_DELAY(RD), .RPT_PERIOD(RP), .BLINK_HALF(BH)
  ) dut (
    .CLK_100MHZ(clk), .RST(rst), .BTN(btn), .SET_EN(set_en),
    .HR_INC(hr_inc), .HR_DEC(hr_dec), .MIN_INC(min_inc), .MIN_DEC(min_dec),
    .SEC_CLR(sec_clr), .TICK_HOLD(tick_hold), .BLINK(blink)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model ----------------
  // Buttons: raw level delayed two samples, a debounced level that moves to v
  // once the last DEB delayed samples all equal v, and only after a first
  // run of DEB low samples. Commands: with the press pulse one cycle after
  // latching (held=1), pulses fall at held = 1, RD+1, RD+1+RP, ...
  logic [3:0]     h1 = 4'd0, h2 = 4'd0, m_sy = 4'd0, mdeb = 4'd0;
  logic [DEB-1:0] win [4] = '{default: '1};
  bit   [3:0]     mq = 4'd0;
  bit             m_set = 1'b0;
  bit             m_wait = 1'b0;
  int             m_lat = -1;
  int             m_held = 0;
  int             m_setcyc = 0;
  logic [3:0]     m_cmd = 4'd0;
  logic           m_sec = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h1 = 4'd0; h2 = 4'd0; mdeb = 4'd0; mq = 4'd0;
      for (int b = 0; b < 4; b++) win[b] = '1;
      m_set = 1'b0; m_wait = 1'b0; m_lat = -1; m_held = 0; m_setcyc = 0;
      m_cmd = 4'd0; m_sec = 1'b0;
    end else begin
      m_cmd = 4'd0;
      m_sec = 1'b0;
      if (!m_set) begin
        if (set_en) begin
          m_set = 1'b1;
          m_setcyc = 0;
        end
      end else if (!set_en) begin
        m_set = 1'b0; m_lat = -1; m_wait = 1'b0; m_setcyc = 0;
      end else begin
        m_setcyc++;
        if (m_lat >= 0) begin
          m_held++;
          if (m_held == 1 ||
              (mdeb[m_lat] && m_held >= RD + 1 && ((m_held - RD - 1) % RP) == 0)) begin
            m_cmd[m_lat] = 1'b1;
            m_sec = (m_lat <= 1);
          end else if (!mdeb[m_lat]) begin
            m_wait = (mdeb != 4'd0);
            m_lat = -1;
          end
        end else if (m_wait) begin
          if (mdeb == 4'd0) m_wait = 1'b0;
        end else if (mdeb != 4'd0) begin
          for (int i = 0; i < 4; i++) if (mdeb[i]) m_lat = i;
          m_held = 0;
        end
      end
      m_sy = h2; h2 = h1; h1 = btn;
      for (int b = 0; b < 4; b++) begin
        win[b] = {win[b][DEB-2:0], m_sy[b]};
        if (!mq[b]) begin
          if (win[b] == '0) mq[b] = 1'b1;
        end else if (&win[b]) begin
          mdeb[b] = 1'b1;
        end else if (win[b] == '0) begin
          mdeb[b] = 1'b0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("hr_inc",    hr_inc,    m_cmd[3]);
      check("hr_dec",    hr_dec,    m_cmd[2]);
      check("min_inc",   min_inc,   m_cmd[1]);
      check("min_dec",   min_dec,   m_cmd[0]);
      check("sec_clr",   sec_clr,   m_sec);
      check("tick_hold", tick_hold, m_set);
      check("blink",     blink,
            m_set && (m_lat < 0) && (((m_setcyc / BH) % 2) == 1));
      check("onehot", ($countones({hr_inc, hr_dec, min_inc, min_dec}) <= 1), 1);
    end
  end

  // ---------------- pulse monitor ----------------
  int n_hi = 0, n_hd = 0, n_mi = 0, n_md = 0, n_sc = 0;
  int hq[$];
  always @(negedge clk) begin
    if (hr_inc)  begin n_hi++; hq.push_back(cyc); end
    if (hr_dec)  n_hd++;
    if (min_inc) n_mi++;
    if (min_dec) n_md++;
    if (sec_clr) n_sc++;
  end

  int s_hi, s_hd, s_mi, s_md, s_sc, s_q, c0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic snap();
    s_hi = n_hi; s_hd = n_hd; s_mi = n_mi; s_md = n_md; s_sc = n_sc; s_q = hq.size();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    tick(1);
    chk_en = 1'b1;
    check("rst_tick_hold", tick_hold, 0);
    check("rst_blink", blink, 0);
    check("rst_hr_inc", hr_inc, 0);
    tick(2);
    rst = 1'b0;
    tick(10);

    // Blink phase from set-mode entry: 8 low, 8 high, then low again.
    set_en = 1'b1;
    tick(1);
    check("armed_tick_hold", tick_hold, 1);
    check("blink_n0", blink, 0);
    tick(7);
    check("blink_n7", blink, 0);
    tick(1);
    check("blink_n8", blink, 1);
    tick(8);
    check("blink_n16", blink, 0);

    // Short bouncy minute-up press: one MIN_INC with SEC_CLR.
    snap();
    btn[1] = 1'b1; tick(1);
    btn[1] = 1'b0; tick(1);
    btn[1] = 1'b1; tick(16);
    btn[1] = 1'b0; tick(12);
    check("short_min_inc", n_mi - s_mi, 1);
    check("short_sec_clr", n_sc - s_sc, 1);
    check("short_other", (n_hi - s_hi) + (n_hd - s_hd) + (n_md - s_md), 0);

    // Hour-up held 60 cycles: press pulse, then repeats 20, 25, ... 55 later.
    snap();
    c0 = cyc;
    btn[3] = 1'b1; tick(30);
    check("held_blink", blink, 0);
    tick(30);
    btn[3] = 1'b0; tick(15);
    check("rpt_count", n_hi - s_hi, 9);
    check("rpt_sec_clr", n_sc - s_sc, 0);
    if (hq.size() >= s_q + 9) begin
      check("rpt_latency", hq[s_q] - c0, DEB + 4);
      check("rpt_gap_first", hq[s_q + 1] - hq[s_q], 20);
      for (int k = 2; k < 9; k++)
        check("rpt_gap", hq[s_q + k] - hq[s_q + k - 1], 5);
    end

    // Hour-down and minute-down together: hour wins, minute needs a re-press.
    snap();
    btn = 4'b0101; tick(10);
    btn[2] = 1'b0; tick(15);
    check("pair_hr_dec", n_hd - s_hd, 1);
    check("pair_min_dec", n_md - s_md, 0);
    btn[0] = 1'b0; tick(12);
    check("pair_min_dec_rel", n_md - s_md, 0);
    btn[0] = 1'b1; tick(12);
    btn[0] = 1'b0; tick(12);
    check("repress_min_dec", n_md - s_md, 1);
    check("repress_sec_clr", n_sc - s_sc, 1);

    // Set mode off: buttons do nothing.
    set_en = 1'b0; tick(3);
    snap();
    btn = 4'b1111; tick(15);
    check("off_tick_hold", tick_hold, 0);
    check("off_blink", blink, 0);
    btn = 4'b0000; tick(10);
    check("off_pulses", (n_hi - s_hi) + (n_hd - s_hd) + (n_mi - s_mi) + (n_md - s_md), 0);

    // SET_EN drops during repeat: three pulses before, none after.
    set_en = 1'b1; tick(3);
    snap();
    btn[3] = 1'b1; tick(35);
    check("drop_before", n_hi - s_hi, 3);
    set_en = 1'b0;
    snap();
    tick(1);
    check("drop_tick_hold", tick_hold, 0);
    tick(20);
    btn[3] = 1'b0; tick(10);
    check("drop_after", n_hi - s_hi, 0);

    // Asynchronous reset while holding minute-up.
    set_en = 1'b1; tick(3);
    btn[1] = 1'b1; tick(12);
    check("pre_rst_tick_hold", tick_hold, 1);
    #2 rst = 1'b1;
    #1;
    check("async_tick_hold", tick_hold, 0);
    check("async_blink", blink, 0);
    check("async_min_inc", min_inc, 0);
    check("async_sec_clr", sec_clr, 0);
    tick(3);
    rst = 1'b0;

    // Button held through reset release gives nothing until released.
    snap();
    tick(30);
    check("held_thru_rst", n_mi - s_mi, 0);
    btn[1] = 1'b0; tick(12);
    btn[1] = 1'b1; tick(12);
    btn[1] = 1'b0; tick(12);
    check("after_rst_press", n_mi - s_mi, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
